// File: rtl/interrupt_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_scheduler_pkg
// Shared definitions for the interrupt scheduler:
//   - grant_type_e  : encoding driven on grant_Type
//   - sched_state_e : scheduler FSM state encoding
//   - PEND_*        : bit positions inside the pending vector
//   - grant_mask()  : maps a grant type onto its pending bit
// -----------------------------------------------------------------------------
package interrupt_scheduler_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE     = 2'b00,
        GRANT_PED_HORI = 2'b01,
        GRANT_PED_VERT = 2'b10,
        GRANT_POLICE   = 2'b11
    } grant_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } sched_state_e;

    localparam int NUM_REQ     = 3;
    localparam int PEND_HORI   = 0;
    localparam int PEND_VERT   = 1;
    localparam int PEND_POLICE = 2;

    function automatic logic [NUM_REQ-1:0] grant_mask(input grant_type_e t);
        logic [NUM_REQ-1:0] m;
        m = '0;
        case (t)
            GRANT_PED_HORI: m[PEND_HORI]   = 1'b1;
            GRANT_PED_VERT: m[PEND_VERT]   = 1'b1;
            GRANT_POLICE:   m[PEND_POLICE] = 1'b1;
            default:        m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/interrupt_scheduler_debouncer.sv
// -----------------------------------------------------------------------------
// interrupt_debouncer
// Per-input debounce filter. The output is high only while the input has been
// sampled high for DEBOUNCE_CYCLES consecutive rising edges; any low sample
// restarts the count. Only instantiated when INTERRUPT_DEBOUNCE_EN is defined.
// Ports:
//   clock    in  system clock
//   reset    in  asynchronous active-high reset
//   i_level  in  raw request level
//   o_level  out filtered request level
// DEBOUNCE_CYCLES is expected to be at least 1.
// -----------------------------------------------------------------------------
module interrupt_debouncer #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_cnt;

    // Count saturates at the terminal value so a long press stays high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_level) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_TC) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = (r_cnt == CNT_TC);

endmodule

// File: rtl/interrupt_scheduler.sv
// -----------------------------------------------------------------------------
// interrupt_scheduler
// Latches pedestrian/police requests as pending bits on rising edges and
// presents them one at a time to the turn controller over a valid/ack
// handshake, with a cooldown between grants and a timeout that drops grants
// the controller never accepts.
//
// Optional build macro: INTERRUPT_DEBOUNCE_EN -- when defined every request
// input passes through an interrupt_debouncer before edge detection.
//
// Ports:
//   clock            in   system clock (rising edge)
//   reset            in   asynchronous active-high reset
//   ped_Hori_Button  in   horizontal pedestrian request level
//   ped_Vert_Button  in   vertical pedestrian request level
//   police_Button    in   police override request level
//   turn             in   0 = vertical pedestrians served, 1 = horizontal
//   grant_Ack        in   controller accepts the current grant
//   grant_Valid      out  a grant is presented
//   grant_Type       out  00 none, 01 ped_hori, 10 ped_vert, 11 police
//   pending          out  latched requests {police, ped_vert, ped_hori}
//   dropped_Count    out  saturating count of timed-out grants
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no grant outstanding, pick the next eligible pending request
// ST_GRANT    | grant presented, waiting for ack or ack timeout
// ST_COOLDOWN | enforced idle gap after a completed or dropped grant
// -----------------------------------------------------------------------------
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 20,
    parameter int ACK_TIMEOUT     = 31,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_Hori_Button,
    input  logic       ped_Vert_Button,
    input  logic       police_Button,
    input  logic       turn,
    input  logic       grant_Ack,
    output logic       grant_Valid,
    output logic [1:0] grant_Type,
    output logic [2:0] pending,
    output logic [7:0] dropped_Count
);

    localparam int CCW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
    localparam int WW  = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOLDOWN_CYCLES);
    localparam logic [CCW-1:0] COOL_TC   = CCW'(1);
    localparam logic [WW-1:0]  WAIT_TC   = WW'(ACK_TIMEOUT);
    localparam logic [WW-1:0]  WAIT_INIT = WW'(1);

    // ---------------------------------------------------------------------
    // Input conditioning and edge detection
    // ---------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_raw;
    logic [NUM_REQ-1:0] w_lvl;
    logic [NUM_REQ-1:0] r_in;
    logic [NUM_REQ-1:0] r_in_d;
    logic [NUM_REQ-1:0] w_edge;

    assign w_raw[PEND_HORI]   = ped_Hori_Button;
    assign w_raw[PEND_VERT]   = ped_Vert_Button;
    assign w_raw[PEND_POLICE] = police_Button;

`ifdef INTERRUPT_DEBOUNCE_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_deb
        interrupt_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock   (clock),
            .reset   (reset),
            .i_level (w_raw[gi]),
            .o_level (w_lvl[gi])
        );
    end
`else
    logic w_unused_deb;
    assign w_lvl        = w_raw;
    assign w_unused_deb = (DEBOUNCE_CYCLES != 0);
`endif

    // r_in registers the level once; r_in_d holds the previous sample so the
    // edge appears one cycle after the level is captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in   <= '0;
            r_in_d <= '0;
        end else begin
            r_in   <= w_lvl;
            r_in_d <= r_in;
        end
    end

    assign w_edge = r_in & ~r_in_d;

    // ---------------------------------------------------------------------
    // Scheduler state
    // ---------------------------------------------------------------------
    sched_state_e       r_state;
    sched_state_e       w_state_n;
    logic [NUM_REQ-1:0] r_pend;
    logic [NUM_REQ-1:0] w_pend_n;
    logic [NUM_REQ-1:0] w_clr;
    logic               r_valid;
    logic               w_valid_n;
    grant_type_e        r_type;
    grant_type_e        w_type_n;
    grant_type_e        w_sel;
    logic [CCW-1:0]     r_cool;
    logic [CCW-1:0]     w_cool_n;
    logic [WW-1:0]      r_wait;
    logic [WW-1:0]      w_wait_n;
    logic [7:0]         r_drop;
    logic [7:0]         w_drop_n;
    logic               w_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_type  <= GRANT_NONE;
            r_cool  <= '0;
            r_wait  <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= w_pend_n;
            r_valid <= w_valid_n;
            r_type  <= w_type_n;
            r_cool  <= w_cool_n;
            r_wait  <= w_wait_n;
            r_drop  <= w_drop_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_valid_n = r_valid;
        w_type_n  = r_type;
        w_cool_n  = r_cool;
        w_wait_n  = r_wait;
        w_drop_n  = r_drop;
        w_clr     = '0;
        w_sel     = GRANT_NONE;
        w_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A pedestrian request for the direction not being served
                // is simply left pending until turn flips.
                if (r_pend[PEND_POLICE]) begin
                    w_sel = GRANT_POLICE;
                end else if (!turn && r_pend[PEND_VERT]) begin
                    w_sel = GRANT_PED_VERT;
                end else if (turn && r_pend[PEND_HORI]) begin
                    w_sel = GRANT_PED_HORI;
                end
                if (w_sel != GRANT_NONE) begin
                    w_state_n = ST_GRANT;
                    w_valid_n = 1'b1;
                    w_type_n  = w_sel;
                    // Wait counter includes the first GRANT cycle.
                    w_wait_n  = WAIT_INIT;
                end
            end

            ST_GRANT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (grant_Ack) begin
                    w_clr  = grant_mask(r_type);
                    w_done = 1'b1;
                end else if (r_wait == WAIT_TC) begin
                    w_clr  = grant_mask(r_type);
                    w_done = 1'b1;
                    if (r_drop != 8'hFF) begin
                        w_drop_n = r_drop + 8'd1;
                    end
                end else begin
                    w_wait_n = r_wait + 1'b1;
                end

                if (w_done) begin
                    w_valid_n = 1'b0;
                    w_type_n  = GRANT_NONE;
                    w_wait_n  = '0;
                    if (COOLDOWN_CYCLES == 0) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_COOLDOWN;
                        w_cool_n  = COOL_LOAD;
                    end
                end
            end

            ST_COOLDOWN: begin
                // Loaded with COOLDOWN_CYCLES, leaves after the cycle at 1,
                // giving exactly COOLDOWN_CYCLES cycles in this state.
                if (r_cool == COOL_TC) begin
                    w_state_n = ST_IDLE;
                    w_cool_n  = '0;
                end else begin
                    w_cool_n = r_cool - 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_valid_n = 1'b0;
                w_type_n  = GRANT_NONE;
            end
        endcase

        // New edges are OR-ed in after the clear so a fresh request for the
        // source being retired in the same cycle is kept.
        w_pend_n = (r_pend & ~w_clr) | w_edge;
    end

    assign grant_Valid   = r_valid;
    assign grant_Type    = r_type;
    assign pending       = r_pend;
    assign dropped_Count = r_drop;

endmodule
